// File: rtl/network_vc_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// network_vc_tx_scheduler_if
//   Bundles the requester-side flit bus and the router-facing Tx bus of the
//   VC transmit scheduler.
//   slave  : used by the scheduler (consumes requests, drives Tx port)
//   master : used by the requesters/router model (drives requests, ready)
// Signals
//   req_valid_i / req_ready_o            per-requester handshake (N bits)
//   req_flit_i / _flit_type_i / _broadcast_i   packed per-requester payload
//   network_valid_o / network_ready_i    Tx valid pulse, per-VC ready
//   network_flit_o / _flit_type_o / _broadcast_o / _virtual_channel_id_o
// ----------------------------------------------------------------------------
interface network_vc_tx_scheduler_if #(
  parameter int NetworkIfFlitWidth               = 64,
  parameter int NetworkIfFlitTypeWidth           = 2,
  parameter int NetworkIfBroadcastWidth          = 1,
  parameter int NetworkIfVirtualChannelIdWidth   = 2,
  parameter int NetworkIfNumberOfVirtualChannels = 4
);
  localparam int N   = NetworkIfNumberOfVirtualChannels;
  localparam int FW  = NetworkIfFlitWidth;
  localparam int TW  = NetworkIfFlitTypeWidth;
  localparam int BW  = NetworkIfBroadcastWidth;
  localparam int VCW = NetworkIfVirtualChannelIdWidth;

  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*FW-1:0] req_flit_i;
  logic [N*TW-1:0] req_flit_type_i;
  logic [N*BW-1:0] req_broadcast_i;
  logic            network_valid_o;
  logic [N-1:0]    network_ready_i;
  logic [FW-1:0]   network_flit_o;
  logic [TW-1:0]   network_flit_type_o;
  logic [BW-1:0]   network_broadcast_o;
  logic [VCW-1:0]  network_virtual_channel_id_o;

  modport slave (
    input  req_valid_i, req_flit_i, req_flit_type_i, req_broadcast_i, network_ready_i,
    output req_ready_o, network_valid_o, network_flit_o, network_flit_type_o,
           network_broadcast_o, network_virtual_channel_id_o
  );

  modport master (
    output req_valid_i, req_flit_i, req_flit_type_i, req_broadcast_i, network_ready_i,
    input  req_ready_o, network_valid_o, network_flit_o, network_flit_type_o,
           network_broadcast_o, network_virtual_channel_id_o
  );
endinterface

// File: rtl/network_vc_tx_scheduler.sv
// ----------------------------------------------------------------------------
// network_vc_tx_scheduler
//   Shares the NI transmit channel among N flit requesters (requester i -> VC i)
//   with packet-level round-robin arbitration: a grant is held from header to
//   tail so packets never interleave. One registered output stage feeds the
//   router injection port (1-cycle latency, 1 flit/cycle).
// Ports
//   clk_network_i   network clock
//   rst_network_ni  asynchronous active-low reset
//   tx_if           scheduler side (slave modport) of the request/Tx bus
//   error_o         sticky per-requester protocol error
// Optional feature
//   NETWORK_VC_TX_SCHEDULER_ERR_EN : in IDLE, payload/tail flits arriving
//   without a header are drained and flag error_o[i]. Undefined: such a
//   requester simply stalls and error_o is tied low.
//
//   state  | meaning
//   IDLE   | no packet in flight, arbitrate among header/header_tail flits
//   LOCKED | owner holds the channel until its tail transfers
// ----------------------------------------------------------------------------
module network_vc_tx_scheduler #(
  parameter int NetworkIfFlitWidth               = 64,
  parameter int NetworkIfFlitTypeWidth           = 2,
  parameter int NetworkIfBroadcastWidth          = 1,
  parameter int NetworkIfVirtualChannelIdWidth   = 2,
  parameter int NetworkIfNumberOfVirtualChannels = 4
) (
  input  logic                                        clk_network_i,
  input  logic                                        rst_network_ni,
  network_vc_tx_scheduler_if.slave                    tx_if,
  output logic [NetworkIfNumberOfVirtualChannels-1:0] error_o
);
  localparam int N   = NetworkIfNumberOfVirtualChannels;
  localparam int FW  = NetworkIfFlitWidth;
  localparam int TW  = NetworkIfFlitTypeWidth;
  localparam int BW  = NetworkIfBroadcastWidth;
  localparam int VCW = NetworkIfVirtualChannelIdWidth;

  localparam logic [TW-1:0] TypeHeader     = TW'(0);
  localparam logic [TW-1:0] TypePayload    = TW'(1);
  localparam logic [TW-1:0] TypeTail       = TW'(2);
  localparam logic [TW-1:0] TypeHeaderTail = TW'(3);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e         state_q, state_d;
  logic [VCW-1:0] rr_ptr_q, rr_ptr_d;
  logic [VCW-1:0] owner_q, owner_d;
  logic           valid_q;
  logic [FW-1:0]  flit_q;
  logic [TW-1:0]  type_q;
  logic [BW-1:0]  bcast_q;
  logic [VCW-1:0] vc_q;

  logic [TW-1:0]  type_a [N];
  logic [N-1:0]   eligible;
  logic [N-1:0]   ready;
  logic           fwd_valid;
  logic [VCW-1:0] fwd_idx;
  logic           found;
  logic [VCW-1:0] sel;
  int             idx;

  function automatic logic [VCW-1:0] next_ptr(input logic [VCW-1:0] p);
    if (int'(p) == N - 1) return '0;
    return p + VCW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      type_a[i]   = tx_if.req_flit_type_i[i*TW +: TW];
      eligible[i] = tx_if.req_valid_i[i] & tx_if.network_ready_i[i] &
                    ((type_a[i] == TypeHeader) | (type_a[i] == TypeHeaderTail));
    end
  end

  // Rotating priority scan starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = VCW'(idx);
      end
    end
  end

`ifdef NETWORK_VC_TX_SCHEDULER_ERR_EN
  logic [N-1:0] err_q, err_d;
  logic         drained;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    ready     = '0;
    fwd_valid = 1'b0;
    fwd_idx   = owner_q;
`ifdef NETWORK_VC_TX_SCHEDULER_ERR_EN
    err_d     = err_q;
    drained   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          ready[sel] = 1'b1;
          fwd_valid  = 1'b1;
          fwd_idx    = sel;
          if (type_a[sel] == TypeHeader) begin
            state_d = ST_LOCKED;
            owner_d = sel;
          end else begin
            rr_ptr_d = next_ptr(sel);
          end
        end
`ifdef NETWORK_VC_TX_SCHEDULER_ERR_EN
        else begin
          // Orphan payload/tail: swallow it so the requester cannot wedge.
          for (int i = 0; i < N; i++) begin
            if (!drained && tx_if.req_valid_i[i] &&
                ((type_a[i] == TypePayload) || (type_a[i] == TypeTail))) begin
              drained  = 1'b1;
              ready[i] = 1'b1;
              err_d[i] = 1'b1;
            end
          end
        end
`endif
      end
      ST_LOCKED: begin
        ready[owner_q] = tx_if.network_ready_i[owner_q];
        if (tx_if.req_valid_i[owner_q] && tx_if.network_ready_i[owner_q]) begin
          fwd_valid = 1'b1;
          // Stray headers from the owner pass through; only the tail unlocks.
          if (type_a[owner_q] == TypeTail) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr(owner_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
    if (!rst_network_ni) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      flit_q   <= '0;
      type_q   <= '0;
      bcast_q  <= '0;
      vc_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      valid_q  <= fwd_valid;
      if (fwd_valid) begin
        flit_q  <= tx_if.req_flit_i[int'(fwd_idx)*FW +: FW];
        type_q  <= type_a[fwd_idx];
        bcast_q <= tx_if.req_broadcast_i[int'(fwd_idx)*BW +: BW];
        vc_q    <= fwd_idx;
      end
    end
  end

`ifdef NETWORK_VC_TX_SCHEDULER_ERR_EN
  always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
    if (!rst_network_ni) err_q <= '0;
    else                 err_q <= err_d;
  end
  assign error_o = err_q;
`else
  assign error_o = '0;
`endif

  // Ready is forced low while reset is held so no flit is lost upstream.
  assign tx_if.req_ready_o                  = rst_network_ni ? ready : '0;
  assign tx_if.network_valid_o              = valid_q;
  assign tx_if.network_flit_o               = flit_q;
  assign tx_if.network_flit_type_o          = type_q;
  assign tx_if.network_broadcast_o          = bcast_q;
  assign tx_if.network_virtual_channel_id_o = vc_q;
endmodule
